// File: rtl/seg_char_sequencer.sv
// seg_char_sequencer
// Buffers received ASCII bytes, interprets control codes (CR, LF/FF, BS),
// sends printable bytes to the ASCII-to-segment converter and commits the
// returned pattern to the display driver at an auto-advancing cursor.

module seg_char_sequencer #(
    parameter int BYTE_W      = 8,
    parameter int CAN_CT      = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int CVT_TIMEOUT = 16
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [BYTE_W-1:0]           rx_data,
    input  logic                        rx_rdy,
    output logic [BYTE_W-1:0]           cvt_char,
    output logic                        cvt,
    input  logic [BYTE_W-1:0]           seg_in,
    input  logic                        seg_ud,
    output logic [BYTE_W-1:0]           seg_out,
    output logic [$clog2(CAN_CT)-1:0]   char_sel,
    output logic                        commit_char,
    output logic                        clear_buffer,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int SEL_W = $clog2(CAN_CT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMO_W = $clog2(CVT_TIMEOUT) + 1;

    localparam logic [BYTE_W-1:0] CH_BS  = BYTE_W'(8'h08);
    localparam logic [BYTE_W-1:0] CH_LF  = BYTE_W'(8'h0A);
    localparam logic [BYTE_W-1:0] CH_FF  = BYTE_W'(8'h0C);
    localparam logic [BYTE_W-1:0] CH_CR  = BYTE_W'(8'h0D);
    localparam logic [BYTE_W-1:0] CH_SP  = BYTE_W'(8'h20);
    localparam logic [BYTE_W-1:0] CH_TLD = BYTE_W'(8'h7E);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_CLEAR  = 3'd4
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   cursor_r;
    logic               advance_r;
    logic [TMO_W-1:0]   wait_cnt_r;

    logic [BYTE_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;

    // Printable range is space through tilde; DEL and lower codes are not.
    function automatic logic is_printable(input logic [BYTE_W-1:0] b);
        return (b >= CH_SP) && (b <= CH_TLD);
    endfunction

    // Cursor advance wraps from the last digit back to the first.
    function automatic logic [SEL_W-1:0] cursor_inc(input logic [SEL_W-1:0] c);
        if (c == SEL_W'(CAN_CT - 1)) begin
            return SEL_W'(0);
        end else begin
            return c + SEL_W'(1);
        end
    endfunction

    // Backspace saturates at the first digit.
    function automatic logic [SEL_W-1:0] cursor_dec(input logic [SEL_W-1:0] c);
        if (c == SEL_W'(0)) begin
            return SEL_W'(0);
        end else begin
            return c - SEL_W'(1);
        end
    endfunction

    assign full_s  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty_s = (fifo_level == LVL_W'(0));
    assign push_s  = rx_rdy && en && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && en && !empty_s;

    // FIFO data storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            fifo_level <= LVL_W'(0);
            overflow   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            // A byte arriving while full is lost even if a pop frees a slot now.
            if (rx_rdy && en && full_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Sequencer FSM with registered strobes and display outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cursor_r     <= SEL_W'(0);
            advance_r    <= 1'b0;
            wait_cnt_r   <= TMO_W'(0);
            cvt_char     <= BYTE_W'(0);
            cvt          <= 1'b0;
            seg_out      <= BYTE_W'(0);
            char_sel     <= SEL_W'(0);
            commit_char  <= 1'b0;
            clear_buffer <= 1'b0;
        end else begin
            cvt          <= 1'b0;
            commit_char  <= 1'b0;
            clear_buffer <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cvt_char <= fifo_mem_r[rd_ptr_r];
                        state_r  <= ST_DECODE;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    if (cvt_char == CH_CR) begin
                        cursor_r <= SEL_W'(0);
                        state_r  <= ST_IDLE;
                    end else if ((cvt_char == CH_LF) || (cvt_char == CH_FF)) begin
                        // Strobe is registered here so it is high during CLEAR.
                        clear_buffer <= 1'b1;
                        state_r      <= ST_CLEAR;
                    end else if (cvt_char == CH_BS) begin
                        cursor_r    <= cursor_dec(cursor_r);
                        char_sel    <= cursor_dec(cursor_r);
                        seg_out     <= BYTE_W'(0);
                        commit_char <= 1'b1;
                        advance_r   <= 1'b0;
                        state_r     <= ST_COMMIT;
                    end else if (is_printable(cvt_char)) begin
                        cvt        <= 1'b1;
                        wait_cnt_r <= TMO_W'(0);
                        state_r    <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (seg_ud) begin
                        seg_out     <= seg_in;
                        char_sel    <= cursor_r;
                        commit_char <= 1'b1;
                        advance_r   <= 1'b1;
                        state_r     <= ST_COMMIT;
                    end else if (wait_cnt_r == TMO_W'(CVT_TIMEOUT - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TMO_W'(1);
                        state_r    <= ST_WAIT;
                    end
                end
                ST_COMMIT: begin
                    if (advance_r) begin
                        cursor_r <= cursor_inc(cursor_r);
                    end else begin
                        cursor_r <= cursor_r;
                    end
                    state_r <= ST_IDLE;
                end
                ST_CLEAR: begin
                    cursor_r <= SEL_W'(0);
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_char_sequencer.sv
// Directed self-checking bench for seg_char_sequencer.

module tb_seg_char_sequencer;

    logic       sys_clk;
    logic       rst_n;
    logic       en;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [7:0] cvt_char;
    logic       cvt;
    logic [7:0] seg_in;
    logic       seg_ud;
    logic [7:0] seg_out;
    logic [2:0] char_sel;
    logic       commit_char;
    logic       clear_buffer;
    logic [3:0] fifo_level;
    logic       overflow;

    int n_checks;
    int n_err;

    seg_char_sequencer #(
        .BYTE_W(8), .CAN_CT(8), .FIFO_DEPTH(8), .CVT_TIMEOUT(16)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .cvt_char(cvt_char), .cvt(cvt),
        .seg_in(seg_in), .seg_ud(seg_ud),
        .seg_out(seg_out), .char_sel(char_sel),
        .commit_char(commit_char), .clear_buffer(clear_buffer),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    // Drive a one-cycle rx strobe; returns at the negedge of the following cycle.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    // Several cycles with no output strobes at all.
    task automatic quiet(input int n, input string tag);
        int strobes = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cvt || commit_char || clear_buffer) strobes++;
        end
        chk(tag, strobes, 0);
    endtask

    // Full printable round trip with a converter answering two cycles after cvt.
    task automatic do_char(input logic [7:0] b, input logic [7:0] seg,
                           input logic [2:0] exp_sel, input string tag);
        int k = 0;
        send(b);
        while (cvt !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_cvt"}, cvt, 1'b1);
        chk({tag, "_cvt_char"}, cvt_char, b);
        tick();
        tick();
        seg_in = seg;
        seg_ud = 1'b1;
        tick();
        seg_ud = 1'b0;
        chk({tag, "_commit"}, commit_char, 1'b1);
        chk({tag, "_seg_out"}, seg_out, seg);
        chk({tag, "_char_sel"}, char_sel, exp_sel);
        tick();
        chk({tag, "_commit_end"}, commit_char, 1'b0);
    endtask

    initial begin
        int cvt_cnt;
        int commit_cnt;
        int cvt_t0;
        int cvt_t1;
        int lvl_at2;
        int lvl_at10;

        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        rx_data  = 8'h00;
        rx_rdy   = 1'b0;
        seg_in   = 8'h00;
        seg_ud   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cvt", cvt, 1'b0);
        chk("rst_commit", commit_char, 1'b0);
        chk("rst_clear", clear_buffer, 1'b0);
        chk("rst_level", fifo_level, 4'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_char_sel", char_sel, 3'd0);
        chk("rst_seg_out", seg_out, 8'h00);
        rst_n = 1'b1;
        tick();

        // 'A' with exact latency: write T, pop T+1, decode T+2, cvt T+3
        send(8'h41);
        chk("a_level_t1", fifo_level, 4'd1);
        tick();
        chk("a_cvt_t2", cvt, 1'b0);
        chk("a_level_t2", fifo_level, 4'd0);
        tick();
        chk("a_cvt_t3", cvt, 1'b1);
        chk("a_cvt_char", cvt_char, 8'h41);
        tick();
        chk("a_cvt_t4", cvt, 1'b0);
        tick();
        tick();
        seg_in = 8'h77;
        seg_ud = 1'b1;
        tick();
        seg_ud = 1'b0;
        seg_in = 8'h00;
        chk("a_commit", commit_char, 1'b1);
        chk("a_seg_out", seg_out, 8'h77);
        chk("a_char_sel", char_sel, 3'd0);
        tick();
        chk("a_commit_once", commit_char, 1'b0);
        chk("a_seg_hold", seg_out, 8'h77);

        // CR returns cursor to 0 silently
        send(8'h0D);
        quiet(4, "cr_quiet");

        // Nine printables wrap the cursor 0..7 then 0
        for (int i = 0; i < 9; i++) begin
            do_char(8'h30 + 8'(i), 8'h01 + 8'(i), 3'(i % 8), "wrap");
        end
        chk("wrap_overflow", overflow, 1'b0);

        // Backspace
        send(8'h0D);
        quiet(3, "cr2_quiet");
        do_char(8'h41, 8'h77, 3'd0, "bs_a");
        do_char(8'h42, 8'h7C, 3'd1, "bs_b");
        send(8'h08);
        tick();
        tick();
        chk("bs_commit", commit_char, 1'b1);
        chk("bs_seg_out", seg_out, 8'h00);
        chk("bs_char_sel", char_sel, 3'd1);
        tick();
        do_char(8'h43, 8'h39, 3'd1, "bs_c");
        send(8'h0D);
        quiet(3, "cr3_quiet");
        send(8'h08);
        tick();
        tick();
        chk("bs0_commit", commit_char, 1'b1);
        chk("bs0_char_sel", char_sel, 3'd0);
        tick();
        do_char(8'h44, 8'h5E, 3'd0, "bs0_d");

        // LF mid-line clears and homes the cursor
        send(8'h0A);
        tick();
        tick();
        chk("lf_clear", clear_buffer, 1'b1);
        chk("lf_no_commit", commit_char, 1'b0);
        tick();
        chk("lf_clear_once", clear_buffer, 1'b0);
        do_char(8'h45, 8'h79, 3'd0, "lf_e");
        send(8'h0C);
        tick();
        tick();
        chk("ff_clear", clear_buffer, 1'b1);
        tick();
        do_char(8'h46, 8'h71, 3'd0, "ff_f");
        send(8'h0D);
        quiet(3, "cr4_quiet");
        do_char(8'h47, 8'h3D, 3'd0, "cr_g");
        send(8'h1B);
        quiet(4, "esc_quiet");
        send(8'h7F);
        quiet(4, "del_quiet");
        do_char(8'h48, 8'h76, 3'd1, "esc_h");

        // Silent converter, ten back-to-back bytes: fill, overflow, timeouts
        cvt_cnt    = 0;
        commit_cnt = 0;
        cvt_t0     = -1;
        cvt_t1     = -1;
        lvl_at2    = -1;
        lvl_at10   = -1;
        for (int c = 0; c < 220; c++) begin
            rx_rdy  = (c < 10);
            rx_data = 8'h50 + 8'(c);
            if (c == 2) lvl_at2 = int'(fifo_level);
            if (c == 10) lvl_at10 = int'(fifo_level);
            if (cvt) begin
                if (cvt_cnt == 0) cvt_t0 = c;
                if (cvt_cnt == 1) cvt_t1 = c;
                cvt_cnt++;
            end
            if (commit_char) commit_cnt++;
            tick();
        end
        rx_rdy = 1'b0;
        chk("ovf_level_pushpop", lvl_at2, 1);
        chk("ovf_level_peak", lvl_at10, 8);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_first_cvt", cvt_t0, 3);
        chk("ovf_timeout_gap", cvt_t1 - cvt_t0, 18);
        chk("ovf_cvt_count", cvt_cnt, 9);
        chk("ovf_no_commit", commit_cnt, 0);
        chk("ovf_drained", fifo_level, 4'd0);

        // Asynchronous reset while waiting on the converter
        send(8'h49);
        tick();
        tick();
        chk("ar_in_wait", cvt, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_cvt", cvt, 1'b0);
        chk("ar_cvt_char", cvt_char, 8'h00);
        chk("ar_overflow", overflow, 1'b0);
        chk("ar_seg_out", seg_out, 8'h00);
        chk("ar_level", fifo_level, 4'd0);
        tick();
        rst_n = 1'b1;
        tick();
        seg_in = 8'h55;
        seg_ud = 1'b1;
        tick();
        seg_ud = 1'b0;
        quiet(5, "ar_late_seg_ud");
        do_char(8'h4A, 8'h1E, 3'd0, "ar_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
